// File: rtl/vga_timing_gen_if.sv
// CPU register-bus bundle for vga_timing_gen (write strobe, index, data, readback).
// Latency: readback is registered, valid one cycle after the address is presented.
// Backpressure: none; every write is accepted on the cycle its strobe is high.
//
// Ports (master = CPU side, slave = timing generator):
//   cfg_we     register write strobe
//   cfg_addr   register index (0..9 used)
//   cfg_wdata  write data, low H_BITS/V_BITS used for timing fields
//   cfg_rdata  staged register value at cfg_addr, zero-extended
interface vga_timing_gen_if;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [15:0] cfg_wdata;
   logic [15:0] cfg_rdata;

   modport master (output cfg_we, output cfg_addr, output cfg_wdata, input cfg_rdata);
   modport slave  (input cfg_we, input cfg_addr, input cfg_wdata, output cfg_rdata);
endinterface

// File: rtl/vga_timing_gen.sv
// Programmable raster timing generator: h/v counters, sync/blank decode, line/frame strobes, raster irq.
// Latency: decoded outputs lead by one cycle (decoded from counter N, shown with counter N+1); readback 1 cycle.
// Backpressure: none; free-running at the pixel clock, register writes always accepted.
//
// Ports:
//   clk, resetn        pixel clock, asynchronous active-low reset
//   cfg                register bus (slave modport of vga_timing_gen_if)
//   vga_hsync/vsync    syncs at programmed polarity; vga_blank high outside visible area
//   h_pos, v_pos       the raster counters themselves
//   line_start         pulse for the first pixel of each line
//   frame_start        pulse for the first pixel of each frame
//   irq, irq_ack       sticky raster-compare interrupt and its clear
module vga_timing_gen #(
   parameter int H_BITS = 11,
   parameter int V_BITS = 11
) (
   input  logic              clk,
   input  logic              resetn,
   vga_timing_gen_if.slave   cfg,
   output logic              vga_hsync,
   output logic              vga_vsync,
   output logic              vga_blank,
   output logic [H_BITS-1:0] h_pos,
   output logic [V_BITS-1:0] v_pos,
   output logic              line_start,
   output logic              frame_start,
   output logic              irq,
   input  logic              irq_ack
);

   // visible, front porch, sync, back porch
   localparam logic [H_BITS-1:0] H_RST [4] = '{H_BITS'(640), H_BITS'(16), H_BITS'(96), H_BITS'(48)};
   localparam logic [V_BITS-1:0] V_RST [4] = '{V_BITS'(480), V_BITS'(10), V_BITS'(2), V_BITS'(33)};

   logic [H_BITS-1:0] stg_h [4];
   logic [V_BITS-1:0] stg_v [4];
   logic [H_BITS-1:0] sh_h  [4];
   logic [V_BITS-1:0] sh_v  [4];
   logic [2:0]        ctrl;
   logic [V_BITS-1:0] irq_line;

   logic              enable;
   logic              hsync_pol;
   logic              vsync_pol;
   logic [H_BITS-1:0] h_total, h_last, hs_start, hs_end;
   logic [V_BITS-1:0] v_total, v_last, vs_start, vs_end;
   logic              h_end, v_end, frame_wrap;
   logic              hs_act, vs_act, visible;
   logic [15:0]       rd_next;
   logic              unused_wdata;

   // Only the low field bits of the write data are architectural.
   assign unused_wdata = ^cfg.cfg_wdata;

   assign enable    = ctrl[2];
   assign hsync_pol = ctrl[0];
   assign vsync_pol = ctrl[1];

   // Staged register file written by the CPU.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stg_h    <= H_RST;
         stg_v    <= V_RST;
         ctrl     <= 3'b100;
         irq_line <= '0;
      end else if (cfg.cfg_we) begin
         case (cfg.cfg_addr)
            4'd0, 4'd1, 4'd2, 4'd3: stg_h[cfg.cfg_addr[1:0]] <= cfg.cfg_wdata[H_BITS-1:0];
            4'd4, 4'd5, 4'd6, 4'd7: stg_v[cfg.cfg_addr[1:0]] <= cfg.cfg_wdata[V_BITS-1:0];
            4'd8:                   ctrl     <= cfg.cfg_wdata[2:0];
            4'd9:                   irq_line <= cfg.cfg_wdata[V_BITS-1:0];
            default: ;
         endcase
      end
   end

   // Derived timing from the shadow copy; sums wrap at the field width.
   assign h_total  = sh_h[0] + sh_h[1] + sh_h[2] + sh_h[3];
   assign h_last   = h_total - H_BITS'(1);
   assign hs_start = sh_h[0] + sh_h[1];
   assign hs_end   = hs_start + sh_h[2];

   assign v_total  = sh_v[0] + sh_v[1] + sh_v[2] + sh_v[3];
   assign v_last   = v_total - V_BITS'(1);
   assign vs_start = sh_v[0] + sh_v[1];
   assign vs_end   = vs_start + sh_v[2];

   assign h_end      = (h_pos == h_last);
   assign v_end      = (v_pos == v_last);
   assign frame_wrap = enable && h_end && v_end;

   // Shadow follows the staged copy continuously while disabled, so a
   // re-enabled raster always starts with the latest programming.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sh_h <= H_RST;
         sh_v <= V_RST;
      end else if (!enable || frame_wrap) begin
         sh_h <= stg_h;
         sh_v <= stg_v;
      end
   end

   // Raster counters.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         h_pos <= '0;
         v_pos <= '0;
      end else if (!enable) begin
         h_pos <= '0;
         v_pos <= '0;
      end else if (h_end) begin
         h_pos <= '0;
         v_pos <= v_end ? '0 : v_pos + V_BITS'(1);
      end else begin
         h_pos <= h_pos + H_BITS'(1);
      end
   end

   assign hs_act  = (h_pos >= hs_start) && (h_pos < hs_end);
   assign vs_act  = (v_pos >= vs_start) && (v_pos < vs_end);
   assign visible = (h_pos < sh_h[0]) && (v_pos < sh_v[0]);

   // Decode of the current counter value, registered so it lines up with the next one.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         vga_hsync   <= 1'b1;
         vga_vsync   <= 1'b1;
         vga_blank   <= 1'b1;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else if (!enable) begin
         vga_hsync   <= ~hsync_pol;
         vga_vsync   <= ~vsync_pol;
         vga_blank   <= 1'b1;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         vga_hsync   <= ~(hs_act ^ hsync_pol);
         vga_vsync   <= ~(vs_act ^ vsync_pol);
         vga_blank   <= ~visible;
         line_start  <= (h_pos == '0);
         frame_start <= (h_pos == '0) && (v_pos == '0);
      end
   end

   // Sticky raster interrupt; a set on the same cycle as an ack wins.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         irq <= 1'b0;
      end else if (enable && (h_pos == '0) && (v_pos == irq_line)) begin
         irq <= 1'b1;
      end else if (irq_ack) begin
         irq <= 1'b0;
      end
   end

   // Readback of the staged copy (pre-write value on a same-cycle write).
   always_comb begin
      rd_next = '0;
      case (cfg.cfg_addr)
         4'd0, 4'd1, 4'd2, 4'd3: rd_next[H_BITS-1:0] = stg_h[cfg.cfg_addr[1:0]];
         4'd4, 4'd5, 4'd6, 4'd7: rd_next[V_BITS-1:0] = stg_v[cfg.cfg_addr[1:0]];
         4'd8:                   rd_next[2:0]        = ctrl;
         4'd9:                   rd_next[V_BITS-1:0] = irq_line;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cfg.cfg_rdata <= '0;
      end else begin
         cfg.cfg_rdata <= rd_next;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: randomized register traffic against a pixel-index reference model.
// Latency: expected outputs are queued one edge ahead and popped by the monitor #1 after each posedge.
// Backpressure: none; the DUT is free-running, so one expectation is queued per driven cycle.
module tb_vga_timing_gen;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        irq_ack = 1'b0;
   logic        vga_hsync, vga_vsync, vga_blank;
   logic [10:0] h_pos;
   logic [10:0] v_pos;
   logic        line_start, frame_start, irq;

   vga_timing_gen_if bus ();

   vga_timing_gen #(.H_BITS(11), .V_BITS(11)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .cfg         (bus),
      .vga_hsync   (vga_hsync),
      .vga_vsync   (vga_vsync),
      .vga_blank   (vga_blank),
      .h_pos       (h_pos),
      .v_pos       (v_pos),
      .line_start  (line_start),
      .frame_start (frame_start),
      .irq         (irq),
      .irq_ack     (irq_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      int h;
      int v;
      bit hs;
      bit vs;
      bit bl;
      bit ls;
      bit fs;
      bit irq;
      int rd;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: raster position is a linear pixel index within the frame.
   int st[10];
   int sh[8];
   int kpix;
   bit m_irq;

   task automatic check(string name, logic [31:0] got, logic [31:0] expv);
      n_cmp++;
      if (got !== expv) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, expv);
      end
   endtask

   task automatic model_reset();
      int d[10];
      d = '{640, 16, 96, 48, 480, 10, 2, 33, 4, 0};
      for (int i = 0; i < 10; i++) st[i] = d[i];
      for (int i = 0; i < 8; i++) sh[i] = d[i];
      kpix  = 0;
      m_irq = 0;
   endtask

   task automatic model_step(bit we, int addr, int wdata, bit ack);
      exp_t e;
      int   htot, vtot, h, v;
      bit   en, hpol, vpol, hs_on, vs_on, set;
      en   = st[8][2];
      hpol = st[8][0];
      vpol = st[8][1];
      htot = sh[0] + sh[1] + sh[2] + sh[3];
      vtot = sh[4] + sh[5] + sh[6] + sh[7];
      h = kpix % htot;
      v = kpix / htot;
      hs_on = en && (h >= sh[0] + sh[1]) && (h < sh[0] + sh[1] + sh[2]);
      vs_on = en && (v >= sh[4] + sh[5]) && (v < sh[4] + sh[5] + sh[6]);
      e.hs  = hs_on ? hpol : !hpol;
      e.vs  = vs_on ? vpol : !vpol;
      e.bl  = !(en && h < sh[0] && v < sh[4]);
      e.ls  = en && (h == 0);
      e.fs  = en && (kpix == 0);
      set   = en && (h == 0) && (v == st[9]);
      m_irq = set ? 1'b1 : (ack ? 1'b0 : m_irq);
      e.irq = m_irq;
      e.rd  = (addr < 10) ? st[addr] : 0;
      if (!en || kpix == htot * vtot - 1) begin
         kpix = 0;
         for (int i = 0; i < 8; i++) sh[i] = st[i];
      end else begin
         kpix++;
      end
      if (we && addr < 10) st[addr] = wdata & ((addr == 8) ? 'h7 : 'h7FF);
      htot = sh[0] + sh[1] + sh[2] + sh[3];
      e.h  = kpix % htot;
      e.v  = kpix / htot;
      q.push_back(e);
   endtask

   // Called at a negedge: drive inputs, queue the expected post-edge outputs, advance a cycle.
   task automatic cycle(bit we, int addr, int wdata, bit ack);
      bus.cfg_we    = we;
      bus.cfg_addr  = addr[3:0];
      bus.cfg_wdata = wdata[15:0];
      irq_ack       = ack;
      model_step(we, addr, wdata, ack);
      @(negedge clk);
   endtask

   function automatic int rand_field(int a);
      int val;
      if (a == 0)      val = $urandom_range(2, 12);
      else if (a == 4) val = $urandom_range(2, 8);
      else             val = $urandom_range(1, 5);
      // junk above the field width must be ignored
      return val | ($urandom_range(0, 31) << 11);
   endfunction

   task automatic check_reset_outputs(string tag);
      check({tag, "_h_pos"},   32'(h_pos), 0);
      check({tag, "_v_pos"},   32'(v_pos), 0);
      check({tag, "_hsync"},   32'(vga_hsync), 1);
      check({tag, "_vsync"},   32'(vga_vsync), 1);
      check({tag, "_blank"},   32'(vga_blank), 1);
      check({tag, "_line"},    32'(line_start), 0);
      check({tag, "_frame"},   32'(frame_start), 0);
      check({tag, "_irq"},     32'(irq), 0);
      check({tag, "_rdata"},   32'(bus.cfg_rdata), 0);
   endtask

   // Monitor: one queued expectation per clock edge while the model is running.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("pos",     {5'd0, h_pos, 5'd0, v_pos}, {5'd0, 11'(e.h), 5'd0, 11'(e.v)});
            check("sync",    {29'd0, vga_hsync, vga_vsync, vga_blank}, {29'd0, e.hs, e.vs, e.bl});
            check("strobe",  {30'd0, line_start, frame_start}, {30'd0, e.ls, e.fs});
            check("irq",     32'(irq), 32'(e.irq));
            check("rdata",   32'(bus.cfg_rdata), 32'(e.rd));
         end
      end
   end

   initial begin
      int a, d;
      bus.cfg_we    = 1'b0;
      bus.cfg_addr  = '0;
      bus.cfg_wdata = '0;
      #1 resetn = 1'b0;
      #1 check_reset_outputs("rst");
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      model_reset();

      // Default 800-wide timing: first lines, hsync window, line strobes.
      for (int i = 0; i < 1700; i++)
         cycle(1'b0, $urandom_range(0, 15), $urandom, $urandom_range(0, 199) == 0);

      // Both syncs active-high while enabled.
      cycle(1'b1, 8, 7, 1'b0);
      for (int i = 0; i < 900; i++) cycle(1'b0, $urandom_range(0, 15), 0, 1'b0);

      // Disable, program a small raster, re-enable.
      cycle(1'b1, 8, 3, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 8, 0, 1'b0);
      for (int r = 0; r < 8; r++) cycle(1'b1, r, rand_field(r), 1'b0);
      cycle(1'b1, 9, 3, 1'b0);
      cycle(1'b1, 8, 4 | $urandom_range(0, 3), 1'b1);

      // Randomized traffic: mid-frame timing writes, polarity/enable flips, irq line moves, acks.
      for (int i = 0; i < 12000; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            a = $urandom_range(0, 11);
            if (a < 8)       d = rand_field(a);
            else if (a == 8) d = ($urandom & 'hFFF8) | (($urandom_range(0, 7) != 0) ? 4 : 0) | $urandom_range(0, 3);
            else if (a == 9) d = $urandom_range(0, 10);
            else             d = $urandom;
            cycle(1'b1, a, d, $urandom_range(0, 3) == 0);
         end else begin
            cycle(1'b0, $urandom_range(0, 15), $urandom, $urandom_range(0, 3) == 0);
         end
      end

      // Make sure the raster is running with a pending irq before the mid-frame reset.
      cycle(1'b1, 8, 4, 1'b0);
      cycle(1'b1, 9, 1, 1'b0);
      for (int i = 0; i < 200 + $urandom_range(0, 100); i++) cycle(1'b0, 9, 0, 1'b0);

      // Asynchronous reset between clock edges.
      #2 resetn = 1'b0;
      #1 check_reset_outputs("arst");
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      model_reset();

      // Readback of reset values, then resumed default counting.
      for (int r = 0; r < 16; r++) cycle(1'b0, r, 0, 1'b0);
      for (int i = 0; i < 300; i++) cycle(1'b0, $urandom_range(0, 15), 0, 1'b0);

      @(posedge clk);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Runtime-programmable raster timing generator, successor to the fixed 640x480 VGA timing block. It produces registered hsync/vsync/blank and the pixel position, with per-axis counter width set by parameter. Horizontal and vertical timing plus sync polarity come from a small register file, which is shadowed and applied only at frame boundaries. It adds line/frame strobes and a sticky raster-compare interrupt, and sits between the CPU register bus and the pixel/colour pipeline.

## Interface
- H_BITS, 11: horizontal counter / field width
- V_BITS, 11: vertical counter / field width
- clk  in  1  pixel clock
- resetn  in  1  asynchronous, active-low reset
- cfg_we  in  1  register write strobe
- cfg_addr  in  4  register index
- cfg_wdata  in  16  write data; low H_BITS/V_BITS used for timing fields
- cfg_rdata  out  16  staged value at cfg_addr, registered, zero-extended
- vga_hsync  out  1  horizontal sync at programmed polarity
- vga_vsync  out  1  vertical sync at programmed polarity
- vga_blank  out  1  1 outside visible area
- h_pos  out  H_BITS  horizontal counter
- v_pos  out  V_BITS  vertical counter
- line_start  out  1  one-cycle pulse, first pixel of each line
- frame_start  out  1  one-cycle pulse, first pixel of each frame
- irq  out  1  sticky raster-compare interrupt
- irq_ack  in  1  clears irq

## Operation
- Registers (staged copy):
  - 0 h_visible, 1 h_front, 2 h_sync, 3 h_back
  - 4 v_visible, 5 v_front, 6 v_sync, 7 v_back
  - 8 ctrl: bit0 hsync_pol, bit1 vsync_pol (1 = active-high), bit2 enable
  - 9 irq_line
  - Other addresses: writes ignored, reads return 0.
- Reset values: 640/16/96/48, 480/10/2/33, ctrl = 3'b100 (enabled, both syncs active-low), irq_line = 0.
- Shadow copy drives the counters. Staged registers 0–7 are copied to the shadow when the counters wrap from (h_total-1, v_total-1) to (0,0), or on any cycle while enable=0.
- ctrl and irq_line act immediately; they are not shadowed.
- h_total = sum of h fields; v_total = sum of v fields. Arithmetic is modulo 2^H_BITS / 2^V_BITS. Software keeps every field ≥1 and totals within range; the block does not check.
- Counting:
  - h_pos increments each cycle and wraps at h_total-1.
  - On each h wrap, v_pos increments and wraps at v_total-1.
- Sync/blank decode from counter value (h,v):
  - hsync asserted for h_visible+h_front ≤ h < h_visible+h_front+h_sync.
  - vsync asserted by the same rule on the v fields.
  - blank = !(h < h_visible && v < v_visible).
  - Driven output level = asserted XNOR pol.
- line_start = (h==0). frame_start = (h==0 && v==0).
- irq:
  - Set when h==0 && v==irq_line.
  - Cleared by irq_ack.
  - If set and ack occur in the same cycle, set wins.
- enable=0:
  - Counters are forced to 0 on the next clock.
  - blank=1, both syncs at inactive level, no strobes or irq sets.
  - irq keeps its value until acked.
  - On re-enable, counting starts from (0,0) with frame_start as the first pulse.

## Timing
- All outputs are registered. Reset values: h_pos=0, v_pos=0, vga_blank=1, vga_hsync=1, vga_vsync=1, line_start=0, frame_start=0, irq=0, cfg_rdata=0.
- h_pos/v_pos are the counters themselves.
- vga_hsync, vga_vsync, vga_blank, line_start, frame_start and irq set are decoded from counter value N and appear one cycle later, i.e. aligned with counter value N+1. Downstream pixel fetch uses this 1-cycle lead.
- cfg write takes effect in the staged copy on the clock edge of cfg_we.
- cfg_rdata is valid 1 cycle after cfg_addr is presented, and reflects a same-cycle write one cycle later.
- A write to registers 0–7 mid-frame does not alter the current frame. It applies from the first cycle with counters at (0,0) after the wrap.
- A write landing on the exact wrap cycle is not guaranteed to be captured for the next frame; it is captured at the following wrap.
- ctrl polarity change is visible on sync outputs 1 cycle after the write.
- Asynchronous reset mid-frame immediately returns all outputs and registers to reset values. Counting restarts at (0,0) on the first clock after release.

## Test plan
- Reset defaults, run 2 frames:
  - Period 800x525.
  - hsync low for h_pos 657..752 (decoded 656..751, one-cycle lag).
  - vsync low for 2 lines from v=490.
  - frame_start every 420000 cycles.
- Program 320/8/32/40, 240/3/4/15 mid-frame:
  - Current frame stays 800x525.
  - Next frame is 400x262; h_pos max 399, v_pos max 261.
- ctrl=3'b111: both syncs active-high; idle level 0 while enabled.
- irq_line=100:
  - irq rises 1 cycle after counter (0,100) and stays high.
  - irq_ack clears it.
  - Ack coinciding with the set cycle leaves irq=1.
- enable cleared at (400,300):
  - Counters 0 next cycle; blank=1, syncs inactive.
  - Re-enable yields frame_start 1 cycle after counting resumes.
- Assert resetn low at (123,45) asynchronously:
  - All outputs take reset values without a clock edge.
  - cfg registers return 640/…/ctrl=4 on readback.
